// File: rtl/game_timer_if.sv
// -----------------------------------------------------------------------------
// game_timer_if
//   Signal bundle between the whack-a-mole game logic and the countdown timer.
//   master : the game side; drives start/tick and observes the timer state.
//   slave  : the timer itself; samples start/tick and drives all status.
//   Signals:
//     start          1  one-cycle start/restart pulse (debounced button)
//     tick           1  1 Hz divider level; only its rising edge counts
//     running        1  high while counting down
//     timer_expired  1  level, high from expiry until the next start/reset
//     expired_pulse  1  one-cycle pulse when timer_expired first rises
//     seconds_left   7  remaining seconds, binary
//     bcd_tens       4  tens digit of seconds_left
//     bcd_ones       4  ones digit of seconds_left
//     warning        1  running and seconds_left at or below the warn level
// -----------------------------------------------------------------------------
interface game_timer_if;
  logic       start;
  logic       tick;
  logic       running;
  logic       timer_expired;
  logic       expired_pulse;
  logic [6:0] seconds_left;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       warning;

  modport master (
    output start,
    output tick,
    input  running,
    input  timer_expired,
    input  expired_pulse,
    input  seconds_left,
    input  bcd_tens,
    input  bcd_ones,
    input  warning
  );

  modport slave (
    input  start,
    input  tick,
    output running,
    output timer_expired,
    output expired_pulse,
    output seconds_left,
    output bcd_tens,
    output bcd_ones,
    output warning
  );
endinterface

// File: rtl/game_timer.sv
// -----------------------------------------------------------------------------
// game_timer
//   Whole-second countdown for the whack-a-mole game. Counts down from
//   GAME_SECONDS on each rising edge of the 1 Hz tick, keeps a binary and a
//   BCD copy of the remaining time in lockstep, flags the last WARN_SECONDS
//   of play and reports expiry as a level plus a one-cycle pulse.
//   Parameters:
//     GAME_SECONDS  game length, 1..99
//     WARN_SECONDS  warning threshold, 0..GAME_SECONDS
//   Ports:
//     clock  100 MHz system clock, rising edge
//     reset  synchronous, active-high
//     bus    game_timer_if.slave (start/tick in, status and count out)
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module game_timer #(
  parameter int unsigned GAME_SECONDS = 30,
  parameter int unsigned WARN_SECONDS = 5
) (
  input  logic         clock,
  input  logic         reset,
  game_timer_if.slave  bus
);

  // Digit split of the game length is a constant; no divider is built.
  localparam logic [6:0] GAME_BIN  = 7'(GAME_SECONDS);
  localparam logic [3:0] GAME_TENS = 4'(GAME_SECONDS / 10);
  localparam logic [3:0] GAME_ONES = 4'(GAME_SECONDS % 10);
  localparam logic [6:0] WARN_BIN  = 7'(WARN_SECONDS);
  localparam logic       GAME_WARN = (GAME_BIN <= WARN_BIN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t state;
  logic   tick_q;
  logic   tick_pend;
  logic   tick_rise;
  logic   start_take;

  assign tick_rise  = bus.tick & ~tick_q;
  // A start is only honoured outside RUNNING; when it is, a tick edge seen
  // in the same cycle is thrown away so the fresh game starts at full count.
  assign start_take = bus.start & (state != RUNNING);

  // NOTE: every state register is assigned with <= so all of them update
  // from the same pre-edge values; a blocking = here would let later
  // statements see half-updated state and change behaviour with ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      tick_q            <= 1'b0;
      tick_pend         <= 1'b0;
      bus.running       <= 1'b0;
      bus.timer_expired <= 1'b0;
      bus.expired_pulse <= 1'b0;
      bus.warning       <= 1'b0;
      bus.seconds_left  <= GAME_BIN;
      bus.bcd_tens      <= GAME_TENS;
      bus.bcd_ones      <= GAME_ONES;
    end else begin
      tick_q            <= bus.tick;
      // The detected edge is registered once before it moves the counter,
      // so a tick first sampled at edge N shows its decrement after N+1.
      tick_pend         <= tick_rise & ~start_take;
      bus.expired_pulse <= 1'b0;

      case (state)
        IDLE, EXPIRED: begin
          if (bus.start) begin
            state             <= RUNNING;
            bus.running       <= 1'b1;
            bus.timer_expired <= 1'b0;
            bus.seconds_left  <= GAME_BIN;
            bus.bcd_tens      <= GAME_TENS;
            bus.bcd_ones      <= GAME_ONES;
            bus.warning       <= GAME_WARN;
          end
        end

        RUNNING: begin
          if (tick_pend) begin
            if (bus.seconds_left == 7'd1) begin
              // Last second: land on zero and stop, never wrap below it.
              state             <= EXPIRED;
              bus.running       <= 1'b0;
              bus.timer_expired <= 1'b1;
              bus.expired_pulse <= 1'b1;
              bus.warning       <= 1'b0;
              bus.seconds_left  <= 7'd0;
              bus.bcd_tens      <= 4'd0;
              bus.bcd_ones      <= 4'd0;
            end else begin
              bus.seconds_left <= bus.seconds_left - 7'd1;
              bus.warning      <= ((bus.seconds_left - 7'd1) <= WARN_BIN);
              // BCD borrow: 0 in the ones place rolls to 9 and takes a ten.
              if (bus.bcd_ones == 4'd0) begin
                bus.bcd_ones <= 4'd9;
                bus.bcd_tens <= bus.bcd_tens - 4'd1;
              end else begin
                bus.bcd_ones <= bus.bcd_ones - 4'd1;
              end
            end
          end
        end

        default: begin
          state       <= IDLE;
          bus.running <= 1'b0;
          bus.warning <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_timer.sv
// -----------------------------------------------------------------------------
// tb_game_timer
//   Directed bench for game_timer. dut_a runs a 3 s game with a 1 s warning,
//   dut_b a 30 s game with the default 5 s warning. Expected values are
//   hand-derived constants; a background monitor also checks that the BCD
//   digits always encode seconds_left and the count never exceeds the load.
// -----------------------------------------------------------------------------
module tb_game_timer;

  logic clock;
  logic reset_a;
  logic reset_b;
  bit   mon_en;
  int   errors;
  int   checks;

  game_timer_if bus_a ();
  game_timer_if bus_b ();

  game_timer #(.GAME_SECONDS(3), .WARN_SECONDS(1)) dut_a (
    .clock (clock),
    .reset (reset_a),
    .bus   (bus_a.slave)
  );

  game_timer #(.GAME_SECONDS(30), .WARN_SECONDS(5)) dut_b (
    .clock (clock),
    .reset (reset_b),
    .bus   (bus_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One full tick period: high across one edge, low across the next.
  task automatic pulse_tick(input bit sel);
    if (sel) bus_b.tick = 1'b1; else bus_a.tick = 1'b1;
    step();
    if (sel) bus_b.tick = 1'b0; else bus_a.tick = 1'b0;
    step();
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    step();
    if (sel) bus_b.start = 1'b0; else bus_a.start = 1'b0;
  endtask

  task automatic check_dut(input string tag, input bit sel, input bit run,
                           input bit expd, input bit pul, input int secs,
                           input int tens, input int ones, input bit warn);
    if (sel) begin
      check({tag, ".running"},       32'(bus_b.running),       32'(run));
      check({tag, ".timer_expired"}, 32'(bus_b.timer_expired), 32'(expd));
      check({tag, ".expired_pulse"}, 32'(bus_b.expired_pulse), 32'(pul));
      check({tag, ".seconds_left"},  32'(bus_b.seconds_left),  32'(secs));
      check({tag, ".bcd_tens"},      32'(bus_b.bcd_tens),      32'(tens));
      check({tag, ".bcd_ones"},      32'(bus_b.bcd_ones),      32'(ones));
      check({tag, ".warning"},       32'(bus_b.warning),       32'(warn));
    end else begin
      check({tag, ".running"},       32'(bus_a.running),       32'(run));
      check({tag, ".timer_expired"}, 32'(bus_a.timer_expired), 32'(expd));
      check({tag, ".expired_pulse"}, 32'(bus_a.expired_pulse), 32'(pul));
      check({tag, ".seconds_left"},  32'(bus_a.seconds_left),  32'(secs));
      check({tag, ".bcd_tens"},      32'(bus_a.bcd_tens),      32'(tens));
      check({tag, ".bcd_ones"},      32'(bus_a.bcd_ones),      32'(ones));
      check({tag, ".warning"},       32'(bus_a.warning),       32'(warn));
    end
  endtask

  // Every-cycle invariants, sampled on the falling edge.
  always @(negedge clock) begin
    if (mon_en) begin
      check("a.bcd_invariant", 32'(bus_a.bcd_tens) * 10 + 32'(bus_a.bcd_ones),
            32'(bus_a.seconds_left));
      check("b.bcd_invariant", 32'(bus_b.bcd_tens) * 10 + 32'(bus_b.bcd_ones),
            32'(bus_b.seconds_left));
      check("a.count_in_range", 32'(bus_a.seconds_left <= 7'd3),  32'd1);
      check("b.count_in_range", 32'(bus_b.seconds_left <= 7'd30), 32'd1);
    end
  end

  initial begin
    errors      = 0;
    checks      = 0;
    mon_en      = 1'b0;
    reset_a     = 1'b1;
    reset_b     = 1'b1;
    bus_a.start = 1'b0;
    bus_a.tick  = 1'b0;
    bus_b.start = 1'b0;
    bus_b.tick  = 1'b0;
    step(2);
    reset_a = 1'b0;
    reset_b = 1'b0;
    mon_en  = 1'b1;

    // Reset values
    check_dut("a.reset", 0, 0, 0, 0, 3, 0, 3, 0);
    check_dut("b.reset", 1, 0, 0, 0, 30, 3, 0, 0);

    // dut_a: start, count 3 -> 2 -> 1 -> 0
    pulse_start(0);
    check_dut("a.start", 0, 1, 0, 0, 3, 0, 3, 0);
    pulse_tick(0);
    check_dut("a.tick1", 0, 1, 0, 0, 2, 0, 2, 0);
    pulse_tick(0);
    check_dut("a.tick2", 0, 1, 0, 0, 1, 0, 1, 1);
    bus_a.tick = 1'b1;
    step();
    check_dut("a.pre_expiry", 0, 1, 0, 0, 1, 0, 1, 1);
    bus_a.tick = 1'b0;
    step();
    check_dut("a.expiry", 0, 0, 1, 1, 0, 0, 0, 0);
    step();
    check_dut("a.post_expiry", 0, 0, 1, 0, 0, 0, 0, 0);
    pulse_tick(0);
    check_dut("a.expired_tick_ignored", 0, 0, 1, 0, 0, 0, 0, 0);

    // dut_a: start and tick rise in the same cycle while EXPIRED
    bus_a.start = 1'b1;
    bus_a.tick  = 1'b1;
    step();
    bus_a.start = 1'b0;
    check_dut("a.collision", 0, 1, 0, 0, 3, 0, 3, 0);
    step();
    check_dut("a.collision_no_dec", 0, 1, 0, 0, 3, 0, 3, 0);
    bus_a.tick = 1'b0;
    step();
    check_dut("a.collision_settled", 0, 1, 0, 0, 3, 0, 3, 0);

    // dut_b: BCD borrow from 30
    pulse_start(1);
    check_dut("b.start", 1, 1, 0, 0, 30, 3, 0, 0);
    pulse_tick(1);
    check_dut("b.borrow_29", 1, 1, 0, 0, 29, 2, 9, 0);
    repeat (12) pulse_tick(1);
    check_dut("b.at_17", 1, 1, 0, 0, 17, 1, 7, 0);

    // Tick held high for 50 cycles counts once
    bus_b.tick = 1'b1;
    step(50);
    bus_b.tick = 1'b0;
    step();
    check_dut("b.held_tick", 1, 1, 0, 0, 16, 1, 6, 0);

    // Start mid-game does not reload
    pulse_start(1);
    step();
    check_dut("b.midgame_start", 1, 1, 0, 0, 16, 1, 6, 0);

    repeat (6) pulse_tick(1);
    check_dut("b.at_10", 1, 1, 0, 0, 10, 1, 0, 0);
    pulse_tick(1);
    check_dut("b.borrow_9", 1, 1, 0, 0, 9, 0, 9, 0);
    repeat (4) pulse_tick(1);
    check_dut("b.warn_at_5", 1, 1, 0, 0, 5, 0, 5, 1);
    repeat (4) pulse_tick(1);
    check_dut("b.at_1", 1, 1, 0, 0, 1, 0, 1, 1);
    pulse_tick(1);
    check_dut("b.expiry", 1, 0, 1, 1, 0, 0, 0, 0);

    // Restart from EXPIRED, run to 17, then reset with a coincident start
    pulse_start(1);
    check_dut("b.restart", 1, 1, 0, 0, 30, 3, 0, 0);
    repeat (13) pulse_tick(1);
    check_dut("b.again_17", 1, 1, 0, 0, 17, 1, 7, 0);
    reset_b     = 1'b1;
    bus_b.start = 1'b1;
    step();
    reset_b     = 1'b0;
    bus_b.start = 1'b0;
    check_dut("b.mid_reset", 1, 0, 0, 0, 30, 3, 0, 0);
    step();
    check_dut("b.reset_start_ignored", 1, 0, 0, 0, 30, 3, 0, 0);

    // Ticks in IDLE are ignored
    repeat (3) pulse_tick(1);
    check_dut("b.idle_ticks", 1, 0, 0, 0, 30, 3, 0, 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_timer.md
# game_timer

Countdown timer for the whack-a-mole game; it drives the `timer_expired` input of the game FSM. It counts whole seconds down from a configurable game length using the 1 Hz clock-divider output. It also presents the remaining time in binary and BCD for the seven-segment display path, and flags the final seconds of play. The block runs entirely in the 100 MHz system clock domain.

## Interface
Parameters:
- `GAME_SECONDS`, default 30: game length in seconds. Legal range 1..99.
- `WARN_SECONDS`, default 5: `warning` asserts while the remaining time is at or below this value. Legal range 0..GAME_SECONDS.

Ports:
- `clock`  in  1  100 MHz system clock; one clock domain, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse from the start-button debouncer; starts or restarts a game.
- `tick`  in  1  1 Hz divider output, a level signal; only its rising edge is used.
- `running`  out  1  high while counting down.
- `timer_expired`  out  1  level, high from expiry until the next start or reset.
- `expired_pulse`  out  1  one-cycle pulse on the cycle `timer_expired` first rises.
- `seconds_left`  out  7  remaining seconds, binary.
- `bcd_tens`  out  4  tens digit of `seconds_left`.
- `bcd_ones`  out  4  ones digit of `seconds_left`.
- `warning`  out  1  `running` and `seconds_left` <= WARN_SECONDS.

## Operation
- Tick edge detect:
  - Register `tick_q`, reset value 0.
  - `tick_rise` = `tick` & ~`tick_q`.
  - A `tick` held high for many cycles counts once.
- FSM states are IDLE, RUNNING and EXPIRED. Reset enters IDLE.
- IDLE:
  - `seconds_left` = GAME_SECONDS; BCD digits hold its decimal digits.
  - `tick_rise` is ignored.
  - `start` loads GAME_SECONDS and moves to RUNNING.
- RUNNING:
  - On `tick_rise`, decrement `seconds_left`.
  - The BCD counter decrements in lockstep: if ones == 0, ones becomes 9 and tens decrements; otherwise ones decrements.
  - When `tick_rise` occurs with `seconds_left` == 1: the counter goes to 0, the FSM moves to EXPIRED, and `expired_pulse` fires.
  - `start` is ignored while RUNNING. There is no mid-game restart.
- EXPIRED:
  - `seconds_left` = 0, BCD = 0/0, `timer_expired` = 1.
  - `tick_rise` is ignored.
  - `start` reloads GAME_SECONDS and moves to RUNNING; `timer_expired` drops.
- Simultaneous `start` and `tick_rise` in IDLE or EXPIRED: `start` wins; the tick is discarded and the counter loads GAME_SECONDS.
- Invariant: `bcd_tens`*10 + `bcd_ones` == `seconds_left` in every cycle. The counter never wraps below 0.
- No divide or modulo in the datapath. The BCD counter is maintained incrementally. The GAME_SECONDS split into tens and ones digits is computed at elaboration time.

## Timing
- Every output is driven from a register; there are no combinational paths from input to output.
- Reset values:
  - `running` 0, `timer_expired` 0, `expired_pulse` 0, `warning` 0.
  - `seconds_left` = GAME_SECONDS.
  - `bcd_tens`/`bcd_ones` = digits of GAME_SECONDS.
- `start` sampled high at edge N: `running` = 1 and the counter is reloaded after edge N.
- `tick` first sampled high at edge N (with `tick_q` = 0): the decremented count is visible after edge N+1.
- Expiry:
  - `seconds_left` = 0, `running` = 0, `timer_expired` = 1 and `expired_pulse` = 1 all appear after the same edge.
  - `expired_pulse` clears after the following edge.
- `warning` updates on the same edge as `seconds_left`.
- `reset` asserted mid-game takes effect at the next edge and returns the block to its IDLE reset values. It overrides `start` and `tick`.
- With a 1 Hz tick, a game lasts GAME_SECONDS ± 1 tick period, measured from `start`.

## Test plan
- **Reset and start (GAME_SECONDS = 3, WARN_SECONDS = 1):**
  - Reset, then pulse `start` → `running` = 1, `seconds_left` = 3, BCD 0/3.
  - Three `tick` rises → count goes 2, 1, 0; `warning` = 1 at 1.
  - `expired_pulse` is exactly one cycle, coincident with `seconds_left` = 0.
  - `timer_expired` stays 1 thereafter.
- **BCD borrow (GAME_SECONDS = 30):**
  - One tick → `seconds_left` = 29, BCD 2/9.
  - Run to 10 and tick once → BCD 0/9.
  - Check the BCD invariant every cycle.
- **Held tick and ignored inputs:**
  - Hold `tick` high for 50 cycles → exactly one decrement.
  - Pulse `start` mid-game → no reload.
  - Ticks in IDLE → `seconds_left` stays GAME_SECONDS.
- **Restart and collision:**
  - In EXPIRED, assert `start` in the same cycle as a `tick` rise → `seconds_left` = GAME_SECONDS, `running` = 1, `timer_expired` = 0, no decrement.
- **Mid-game reset:**
  - Assert `reset` for one cycle at `seconds_left` = 17 → after the next edge, IDLE values with `seconds_left` = 30.
  - A `start` asserted during the reset cycle has no effect.
